// File: rtl/iopad_pkg.sv
// Shared definitions for the bidirectional pad controller: FSM state encoding
// and default turnaround / filter-width settings.
package iopad_pkg;

  localparam int TURN_CYC_DEF = 2;
  localparam int FILT_W_DEF   = 4;

  typedef enum logic [1:0] {
    ST_IN     = 2'd0,
    ST_TO_OUT = 2'd1,
    ST_OUT    = 2'd2,
    ST_TO_IN  = 2'd3
  } pad_state_t;

endpackage

// File: rtl/iopad_in_filt.sv
// Pad receive path: two-flop synchroniser plus optional glitch filter
// (enabled by IOPAD_PDD_CTRL_FILTER_EN); emits level and edge pulses aligned to it.
module iopad_in_filt #(
  parameter int FILT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pad_c,
  input  logic [FILT_W-1:0] filt_len,
  output logic              level,
  output logic              rise,
  output logic              fall
);

  logic sync1, sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pad_c;
      sync2 <= sync1;
    end
  end

`ifdef IOPAD_PDD_CTRL_FILTER_EN
  localparam logic [FILT_W-1:0] CNT_ONE = {{(FILT_W-1){1'b0}}, 1'b1};

  logic [FILT_W-1:0] cnt;
  logic              lvl_q, rise_q, fall_q;

  // Accept a new level once it has differed for filt_len+1 consecutive cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sync2 == lvl_q) begin
        cnt <= '0;
      end else if (cnt == filt_len) begin
        lvl_q  <= sync2;
        rise_q <= sync2;
        fall_q <= ~sync2;
        cnt    <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  assign level = lvl_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
`else
  logic rise_q, fall_q;
  logic unused_filt_len;

  // Edge pulses register alongside sync2 so they coincide with the level change.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= sync1 & ~sync2;
      fall_q <= ~sync1 & sync2;
    end
  end

  assign unused_filt_len = ^filt_len;
  assign level = sync2;
  assign rise  = rise_q;
  assign fall  = fall_q;
`endif

endmodule

// File: rtl/iopad_pdd_ctrl.sv
// Bidirectional pad controller with bus-turnaround FSM and filtered receive path.
// Glitch filter is built only when IOPAD_PDD_CTRL_FILTER_EN is defined.
module iopad_pdd_ctrl
  import iopad_pkg::*;
#(
  parameter int TURN_CYC = TURN_CYC_DEF,
  parameter int FILT_W   = FILT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dir_req,
  input  logic              out_data,
  input  logic              pull_en,
  input  logic [FILT_W-1:0] filt_len,
  input  logic              pad_c,
  output logic              pad_i,
  output logic              pad_oen,
  output logic              pad_ren,
  output logic              in_data,
  output logic              in_rise,
  output logic              in_fall,
  output logic              dir_cur,
  output logic              busy
);

  localparam logic [3:0] TURN_LAST = 4'(TURN_CYC - 1);
  localparam logic [3:0] TCNT_ONE  = 4'd1;

  pad_state_t state_q, state_d;
  logic [3:0] tcnt_q, tcnt_d;
  logic       rise_raw, fall_raw;

  iopad_in_filt #(
    .FILT_W (FILT_W)
  ) u_in_filt (
    .clk      (clk),
    .rst      (rst),
    .pad_c    (pad_c),
    .filt_len (filt_len),
    .level    (in_data),
    .rise     (rise_raw),
    .fall     (fall_raw)
  );

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    dir_cur = 1'b0;
    busy    = 1'b0;
    in_rise = 1'b0;
    in_fall = 1'b0;
    case (state_q)
      ST_IN: begin
        tcnt_d  = '0;
        in_rise = rise_raw;
        in_fall = fall_raw;
        if (dir_req) state_d = ST_TO_OUT;
      end
      ST_TO_OUT: begin
        busy = 1'b1;
        // An early withdrawal aborts before the driver is ever enabled.
        if (!dir_req) begin
          state_d = ST_IN;
          tcnt_d  = '0;
        end else if (tcnt_q == TURN_LAST) begin
          state_d = ST_OUT;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + TCNT_ONE;
        end
      end
      ST_OUT: begin
        dir_cur = 1'b1;
        tcnt_d  = '0;
        if (!dir_req) state_d = ST_TO_IN;
      end
      ST_TO_IN: begin
        busy = 1'b1;
        // Receive turnaround always runs to completion.
        if (tcnt_q == TURN_LAST) begin
          tcnt_d  = '0;
          state_d = dir_req ? ST_TO_OUT : ST_IN;
        end else begin
          tcnt_d = tcnt_q + TCNT_ONE;
        end
      end
      default: begin
        state_d = ST_IN;
        tcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IN;
      tcnt_q  <= '0;
      pad_oen <= 1'b1;
      pad_i   <= 1'b0;
      pad_ren <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      pad_oen <= (state_d != ST_OUT);
      pad_ren <= ~pull_en;
      if (state_q == ST_TO_OUT || state_q == ST_OUT) pad_i <= out_data;
    end
  end

endmodule

// File: tb/tb_iopad_pdd_ctrl.sv
// Directed bench for iopad_pdd_ctrl: table of FSM/pad vectors plus hand sequences
// for receive latency, turnaround pulse suppression and glitch filtering.
module tb_iopad_pdd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dir_req = 1'b0;
  logic       out_data = 1'b0;
  logic       pull_en = 1'b1;
  logic [3:0] filt_len = 4'd0;
  logic       pad_c = 1'b0;
  logic       pad_i, pad_oen, pad_ren, in_data, in_rise, in_fall, dir_cur, busy;

  int n_cmp = 0;
  int n_bad = 0;

  iopad_pdd_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .dir_req  (dir_req),
    .out_data (out_data),
    .pull_en  (pull_en),
    .filt_len (filt_len),
    .pad_c    (pad_c),
    .pad_i    (pad_i),
    .pad_oen  (pad_oen),
    .pad_ren  (pad_ren),
    .in_data  (in_data),
    .in_rise  (in_rise),
    .in_fall  (in_fall),
    .dir_cur  (dir_cur),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       dir;
    logic       od;
    logic       pull;
    logic [7:0] exp;  // {pad_oen, pad_i, pad_ren, dir_cur, busy, in_data, in_rise, in_fall}
  } vec_t;

  vec_t vecs [28];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {pad_oen, pad_i, pad_ren, dir_cur, busy, in_data, in_rise, in_fall};
  endfunction

  int rises, falls, hi_seen, both;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'b1000_0000};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'b1000_0000};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'b1010_0000};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'b1010_1000};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'b1110_1000};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'b0011_0000};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'b0101_0000};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'b0001_0000};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'b1100_1000};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'b1100_1000};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'b1100_0000};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'b1100_1000};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'b1000_0000};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'b1000_0000};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'b1000_1000};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'b1100_1000};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'b0101_0000};
    vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'b1000_0000};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'b1000_0000};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'b1000_1000};
    vecs[20] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'b1100_1000};
    vecs[21] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'b0001_0000};
    vecs[22] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'b1100_1000};
    vecs[23] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'b1100_1000};
    vecs[24] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'b1100_1000};
    vecs[25] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'b1000_1000};
    vecs[26] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'b0001_0000};
    vecs[27] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'b1000_0000};

    #2;
    for (int i = 0; i < 28; i++) begin
      rst      = vecs[i].rst;
      dir_req  = vecs[i].dir;
      out_data = vecs[i].od;
      pull_en  = vecs[i].pull;
      tick();
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Receive latency: 2 edges unfiltered (filt_len ignored), 3 edges filtered with filt_len=0.
    rst = 1'b0; dir_req = 1'b0; out_data = 1'b0;
`ifdef IOPAD_PDD_CTRL_FILTER_EN
    filt_len = 4'd0;
`else
    filt_len = 4'd7;
`endif
    pad_c = 1'b1;
    tick();
    chk("lat_edge1", {7'd0, in_data}, 8'd0);
`ifdef IOPAD_PDD_CTRL_FILTER_EN
    tick();
    chk("lat_edge2", {7'd0, in_data}, 8'd0);
`endif
    tick();
    chk("lat_rise", {6'd0, in_data, in_rise}, 8'b11);
    tick();
    chk("rise_once", {6'd0, in_data, in_rise}, 8'b10);
    pad_c = 1'b0;
    tick();
`ifdef IOPAD_PDD_CTRL_FILTER_EN
    tick();
`endif
    chk("fall_hold", {7'd0, in_data}, 8'd1);
    tick();
    chk("fall_pulse", {5'd0, in_data, in_rise, in_fall}, 8'b001);
    tick();
    chk("fall_once", {5'd0, in_data, in_rise, in_fall}, 8'b000);

    // Level change landing during TO_IN must not pulse in_rise.
    dir_req = 1'b1;
    tick(); tick(); tick();
    chk("to_out_done", {7'd0, dir_cur}, 8'd1);
`ifdef IOPAD_PDD_CTRL_FILTER_EN
    pad_c = 1'b1;
    tick();
`endif
    pad_c = 1'b1;
    dir_req = 1'b0;
    tick();
    chk("to_in_first", {6'd0, pad_oen, busy}, 8'b11);
    tick();
    chk("to_in_nopulse", {5'd0, busy, in_data, in_rise}, 8'b110);
    tick();
    chk("back_in", {5'd0, busy, in_rise, in_fall}, 8'b000);

`ifdef IOPAD_PDD_CTRL_FILTER_EN
    // Glitch filter with filt_len=3: 3-cycle glitch rejected, 4-cycle pulse accepted.
    rst = 1'b1; pad_c = 1'b0; filt_len = 4'd3;
    tick();
    rst = 1'b0;
    tick();
    pad_c = 1'b1;
    rises = 0; falls = 0; hi_seen = 0; both = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      rises += in_rise; hi_seen |= in_data;
    end
    pad_c = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      rises += in_rise; hi_seen |= in_data;
    end
    chk("glitch3_reject", {7'd0, hi_seen[0]}, 8'd0);
    chk("glitch3_norise", 8'(rises), 8'd0);
    pad_c = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      rises += in_rise; falls += in_fall; hi_seen |= in_data; both |= (in_rise & in_fall);
    end
    pad_c = 1'b0;
    for (int c = 0; c < 14; c++) begin
      tick();
      rises += in_rise; falls += in_fall; hi_seen |= in_data; both |= (in_rise & in_fall);
    end
    chk("pulse4_accept", {7'd0, hi_seen[0]}, 8'd1);
    chk("pulse4_onerise", 8'(rises), 8'd1);
    chk("pulse4_onefall", 8'(falls), 8'd1);
    chk("no_rise_fall_both", {7'd0, both[0]}, 8'd0);
    chk("pulse4_final", {7'd0, in_data}, 8'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
